// File: rtl/neuron_lut_loader_if.sv
// rtl/neuron_lut_loader_if.sv - configuration stream and lookup port bundle for neuron_lut_loader
interface neuron_lut_loader_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1
);
    logic                cfg_start;
    logic [7:0]          cfg_data;
    logic                cfg_valid;
    logic                cfg_ready;
    logic                cfg_done;
    logic                table_ok;
    logic [IN_BITS-1:0]  M0;
    logic                M0_valid;
    logic [OUT_BITS-1:0] M1;
    logic                M1_valid;
    logic                lookup_err;

    modport slave (
        input  cfg_start, cfg_data, cfg_valid, M0, M0_valid,
        output cfg_ready, cfg_done, table_ok, M1, M1_valid, lookup_err
    );

    modport master (
        output cfg_start, cfg_data, cfg_valid, M0, M0_valid,
        input  cfg_ready, cfg_done, table_ok, M1, M1_valid, lookup_err
    );
endinterface

// File: rtl/neuron_lut_loader.sv
// rtl/neuron_lut_loader.sv - runtime-loadable neuron truth table with registered lookups
module neuron_lut_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    neuron_lut_loader_if.slave bus
);
    localparam int TBITS  = (1 << IN_BITS) * OUT_BITS;
    localparam int NBYTES = TBITS / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int AW     = CW + 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [TBITS-1:0] mem;

    logic            accept;
    logic            last;
    logic            lk_ok;
    logic [AW-1:0]   wr_base;
    logic [AW-1:0]   rd_base;

    // A cfg_start in the same cycle as a byte wins; that byte is dropped.
    assign accept  = (state == LOAD) && bus.cfg_valid && !bus.cfg_start;
    assign last    = (cnt == CW'(NBYTES - 1));
    assign lk_ok   = (state == READY) && bus.M0_valid && !bus.cfg_start;
    assign wr_base = {cnt, 3'b000};
    assign rd_base = AW'(32'(bus.M0) * OUT_BITS);

    // Table storage is deliberately unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_base +: 8] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.cfg_ready  <= 1'b0;
            bus.cfg_done   <= 1'b0;
            bus.table_ok   <= 1'b0;
            bus.M1         <= '0;
            bus.M1_valid   <= 1'b0;
            bus.lookup_err <= 1'b0;
        end else begin
            bus.cfg_done   <= 1'b0;
            bus.M1_valid   <= lk_ok;
            bus.lookup_err <= bus.M0_valid && !lk_ok;
            if (lk_ok) begin
                bus.M1 <= mem[rd_base +: OUT_BITS];
            end

            if (bus.cfg_start) begin
                state         <= LOAD;
                cnt           <= '0;
                bus.cfg_ready <= 1'b1;
                bus.table_ok  <= 1'b0;
            end else if (accept) begin
                if (last) begin
                    state         <= READY;
                    cnt           <= '0;
                    bus.cfg_ready <= 1'b0;
                    bus.cfg_done  <= 1'b1;
                    bus.table_ok  <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule
